// File: rtl/mem_port2_arbiter.sv
// mem_port2_arbiter
// Shares memory port 2 between the CPU control path and one external
// requester (loader/debug/DMA). Every access runs IDLE -> ISSUE -> WAIT -> RESP.
// The CPU has fixed priority. Two limits keep either side from being shut out:
// a starvation counter forces one external grant, and a burst counter caps
// how many external accesses run back-to-back while the CPU is waiting.
// Optional build macro: ARB_STATS_EN adds the StatCpu/StatExt access counters.

module mem_port2_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int MAX_BURST    = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              CtrlRst,
  input  logic              CpuReq,
  input  logic              CpuWe,
  input  logic [ADDR_W-1:0] CpuAddr,
  input  logic [DATA_W-1:0] CpuWData,
  output logic              CpuStall,
  output logic              CpuDone,
  output logic [DATA_W-1:0] CpuRData,
  input  logic              ExtReq,
  input  logic              ExtWe,
  input  logic [ADDR_W-1:0] ExtAddr,
  input  logic [DATA_W-1:0] ExtWData,
  output logic              ExtGrant,
  output logic              ExtDone,
  output logic [DATA_W-1:0] ExtRData,
  output logic              MemEn,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
`ifdef ARB_STATS_EN
  output logic [15:0]       StatCpu,
  output logic [15:0]       StatExt,
`endif
  input  logic [DATA_W-1:0] MemRData
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } owner_t;

  state_t              state_r;
  state_t              nextState_s;
  owner_t              owner_r;
  logic                weLat_r;
  logic [BW-1:0]       burstCnt_r;
  logic [SW-1:0]       starveCnt_r;

  logic                grantAny_s;
  logic                grantExt_s;
  logic                selWe_s;
  logic [ADDR_W-1:0]   selAddr_s;
  logic [DATA_W-1:0]   selWData_s;
  logic                extGrantNext_s;

  logic                memEn_r;
  logic                memWe_r;
  logic [ADDR_W-1:0]   memAddr_r;
  logic [DATA_W-1:0]   memWData_r;
  logic                extGrant_r;
  logic                cpuDone_r;
  logic                extDone_r;
  logic [DATA_W-1:0]   cpuRData_r;
  logic [DATA_W-1:0]   extRData_r;

  // Arbitration in IDLE: starvation guard, burst continuation, CPU, then external.
  always_comb begin
    grantAny_s = 1'b0;
    grantExt_s = 1'b0;
    if (state_r == IDLE) begin
      if ((starveCnt_r == STARVE_MAX) && ExtReq) begin
        grantAny_s = 1'b1;
        grantExt_s = 1'b1;
      end else if ((owner_r == OWN_EXT) && ExtReq && (burstCnt_r < BURST_MAX)) begin
        grantAny_s = 1'b1;
        grantExt_s = 1'b1;
      end else if (CpuReq) begin
        grantAny_s = 1'b1;
        grantExt_s = 1'b0;
      end else if (ExtReq) begin
        grantAny_s = 1'b1;
        grantExt_s = 1'b1;
      end else begin
        grantAny_s = 1'b0;
        grantExt_s = 1'b0;
      end
    end else begin
      grantAny_s = 1'b0;
      grantExt_s = 1'b0;
    end
  end

  // Select the winning requester's command for latching.
  always_comb begin
    selWe_s    = 1'b0;
    selAddr_s  = {ADDR_W{1'b0}};
    selWData_s = {DATA_W{1'b0}};
    if (grantExt_s) begin
      selWe_s    = ExtWe;
      selAddr_s  = ExtAddr;
      selWData_s = ExtWData;
    end else begin
      selWe_s    = CpuWe;
      selAddr_s  = CpuAddr;
      selWData_s = CpuWData;
    end
  end

  // Next-state logic of the fixed four-phase access sequence.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (grantAny_s) begin
          nextState_s = ISSUE;
        end else begin
          nextState_s = IDLE;
        end
      end
      ISSUE:   nextState_s = WAIT;
      WAIT:    nextState_s = RESP;
      RESP:    nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // Next ExtGrant. Leaving RESP it stays up when the burst is expected to
  // continue, so the external side does not see a one-cycle drop between
  // accesses of its own burst.
  always_comb begin
    extGrantNext_s = 1'b0;
    case (state_r)
      IDLE:        extGrantNext_s = grantExt_s;
      ISSUE, WAIT: extGrantNext_s = (owner_r == OWN_EXT);
      RESP:        extGrantNext_s = (owner_r == OWN_EXT) && ExtReq &&
                                    ((burstCnt_r < BURST_MAX) || !CpuReq);
      default:     extGrantNext_s = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge CtrlRst) begin
    if (CtrlRst) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Latch the owner and access direction when a grant is made.
  always_ff @(posedge CLK or posedge CtrlRst) begin
    if (CtrlRst) begin
      owner_r <= OWN_CPU;
      weLat_r <= 1'b0;
    end else if (grantAny_s) begin
      owner_r <= grantExt_s ? OWN_EXT : OWN_CPU;
      weLat_r <= selWe_s;
    end else begin
      owner_r <= owner_r;
      weLat_r <= weLat_r;
    end
  end

  // Fairness counters: starvation of the external side and external burst length.
  always_ff @(posedge CLK or posedge CtrlRst) begin
    if (CtrlRst) begin
      starveCnt_r <= {SW{1'b0}};
      burstCnt_r  <= {BW{1'b0}};
    end else if (state_r == IDLE) begin
      if (grantAny_s && grantExt_s) begin
        starveCnt_r <= {SW{1'b0}};
        if (owner_r == OWN_EXT) begin
          if (burstCnt_r < BURST_MAX) begin
            burstCnt_r <= burstCnt_r + BW'(1'b1);
          end else begin
            burstCnt_r <= burstCnt_r;
          end
        end else begin
          burstCnt_r <= BW'(1'b1);
        end
      end else if (grantAny_s) begin
        burstCnt_r <= {BW{1'b0}};
        if (ExtReq && (starveCnt_r < STARVE_MAX)) begin
          starveCnt_r <= starveCnt_r + SW'(1'b1);
        end else begin
          starveCnt_r <= starveCnt_r;
        end
      end else if (!ExtReq) begin
        burstCnt_r <= {BW{1'b0}};
      end else begin
        burstCnt_r <= burstCnt_r;
      end
    end else begin
      starveCnt_r <= starveCnt_r;
      burstCnt_r  <= burstCnt_r;
    end
  end

  // Memory command: driven only during ISSUE, zero in every other state.
  always_ff @(posedge CLK or posedge CtrlRst) begin
    if (CtrlRst) begin
      memEn_r    <= 1'b0;
      memWe_r    <= 1'b0;
      memAddr_r  <= {ADDR_W{1'b0}};
      memWData_r <= {DATA_W{1'b0}};
    end else if (grantAny_s) begin
      memEn_r    <= 1'b1;
      memWe_r    <= selWe_s;
      memAddr_r  <= selAddr_s;
      memWData_r <= selWData_s;
    end else begin
      memEn_r    <= 1'b0;
      memWe_r    <= 1'b0;
      memAddr_r  <= {ADDR_W{1'b0}};
      memWData_r <= {DATA_W{1'b0}};
    end
  end

  // Registered external grant.
  always_ff @(posedge CLK or posedge CtrlRst) begin
    if (CtrlRst) begin
      extGrant_r <= 1'b0;
    end else begin
      extGrant_r <= extGrantNext_s;
    end
  end

  // Done pulses: asserted for the single RESP cycle of the owner's access.
  always_ff @(posedge CLK or posedge CtrlRst) begin
    if (CtrlRst) begin
      cpuDone_r <= 1'b0;
      extDone_r <= 1'b0;
    end else begin
      cpuDone_r <= (state_r == WAIT) && (owner_r == OWN_CPU);
      extDone_r <= (state_r == WAIT) && (owner_r == OWN_EXT);
    end
  end

  // Read data capture at the end of WAIT. Writes leave both registers untouched.
  always_ff @(posedge CLK or posedge CtrlRst) begin
    if (CtrlRst) begin
      cpuRData_r <= {DATA_W{1'b0}};
      extRData_r <= {DATA_W{1'b0}};
    end else if ((state_r == WAIT) && !weLat_r) begin
      if (owner_r == OWN_EXT) begin
        extRData_r <= MemRData;
      end else begin
        cpuRData_r <= MemRData;
      end
    end else begin
      cpuRData_r <= cpuRData_r;
      extRData_r <= extRData_r;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] statCpu_r;
  logic [15:0] statExt_r;

  // Completed-access counters, bumped in RESP and wrapping at 0xFFFF.
  always_ff @(posedge CLK or posedge CtrlRst) begin
    if (CtrlRst) begin
      statCpu_r <= 16'h0000;
      statExt_r <= 16'h0000;
    end else if (state_r == RESP) begin
      if (owner_r == OWN_EXT) begin
        statExt_r <= statExt_r + 16'h0001;
      end else begin
        statCpu_r <= statCpu_r + 16'h0001;
      end
    end else begin
      statCpu_r <= statCpu_r;
      statExt_r <= statExt_r;
    end
  end

  assign StatCpu = statCpu_r;
  assign StatExt = statExt_r;
`endif

  assign CpuStall = CpuReq & ~cpuDone_r;
  assign CpuDone  = cpuDone_r;
  assign CpuRData = cpuRData_r;
  assign ExtGrant = extGrant_r;
  assign ExtDone  = extDone_r;
  assign ExtRData = extRData_r;
  assign MemEn    = memEn_r;
  assign MemWe    = memWe_r;
  assign MemAddr  = memAddr_r;
  assign MemWData = memWData_r;

endmodule

// File: tb/tb_mem_port2_arbiter.sv
// tb_mem_port2_arbiter
// Directed scenarios followed by random traffic from both requesters. A
// transaction-level model picks the winner of each arbitration using the
// priority rules. It tracks memory contents and the expected read-data
// registers. The bench includes a simple bus memory that answers the DUT.
// Honours ARB_STATS_EN when the design is built with it.

module tb_mem_port2_arbiter;

  localparam int SL = 4;
  localparam int MB = 4;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } txn_t;

  logic        CLK = 1'b0;
  logic        CtrlRst;
  logic        CpuReq, CpuWe, ExtReq, ExtWe;
  logic [15:0] CpuAddr, CpuWData, ExtAddr, ExtWData;
  logic        CpuStall, CpuDone, ExtGrant, ExtDone;
  logic [15:0] CpuRData, ExtRData;
  logic        MemEn, MemWe;
  logic [15:0] MemAddr, MemWData, MemRData;
`ifdef ARB_STATS_EN
  logic [15:0] StatCpu, StatExt;
`endif

  always #5 CLK = ~CLK;

  mem_port2_arbiter dut (
    .CLK(CLK), .CtrlRst(CtrlRst),
    .CpuReq(CpuReq), .CpuWe(CpuWe), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
    .CpuStall(CpuStall), .CpuDone(CpuDone), .CpuRData(CpuRData),
    .ExtReq(ExtReq), .ExtWe(ExtWe), .ExtAddr(ExtAddr), .ExtWData(ExtWData),
    .ExtGrant(ExtGrant), .ExtDone(ExtDone), .ExtRData(ExtRData),
    .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
`ifdef ARB_STATS_EN
    .StatCpu(StatCpu), .StatExt(StatExt),
`endif
    .MemRData(MemRData)
  );

  // Bus memory: 256 words, read data valid the cycle after MemEn.
  logic [15:0] busMem [0:255];
  logic        memClr, pokeEn;
  logic [7:0]  pokeAddr;
  logic [15:0] pokeData;

  always @(posedge CLK) begin
    if (memClr) begin
      for (int i = 0; i < 256; i++) busMem[i] <= 16'h0000;
    end else if (pokeEn) begin
      busMem[pokeAddr] <= pokeData;
    end else if (MemEn && MemWe) begin
      busMem[MemAddr[7:0]] <= MemWData;
    end
    if (MemEn && !MemWe) MemRData <= busMem[MemAddr[7:0]];
  end

  int vecs = 0;
  int errs = 0;

  txn_t        cpuQ[$];
  txn_t        extQ[$];
  logic [15:0] refMem [0:255];
  int          starveM, burstM, statCpuM, statExtM;
  bit          prevExtM;
  logic [15:0] expCpuR, expExtR;
  logic [31:0] seqBits;
  int          seqLen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(input logic we, input logic [15:0] a, input logic [15:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.data = d;
    return t;
  endfunction

  task automatic driveReqs();
    if (cpuQ.size() > 0) begin
      CpuReq = 1'b1; CpuWe = cpuQ[0].we; CpuAddr = cpuQ[0].addr; CpuWData = cpuQ[0].data;
    end else begin
      CpuReq = 1'b0; CpuWe = 1'b0; CpuAddr = 16'h0000; CpuWData = 16'h0000;
    end
    if (extQ.size() > 0) begin
      ExtReq = 1'b1; ExtWe = extQ[0].we; ExtAddr = extQ[0].addr; ExtWData = extQ[0].data;
    end else begin
      ExtReq = 1'b0; ExtWe = 1'b0; ExtAddr = 16'h0000; ExtWData = 16'h0000;
    end
  endtask

  task automatic modelReset();
    starveM = 0; burstM = 0; prevExtM = 1'b0;
    expCpuR = 16'h0000; expExtR = 16'h0000;
    statCpuM = 0; statExtM = 0;
    cpuQ.delete(); extQ.delete();
    seqBits = 32'h0; seqLen = 0;
  endtask

  task automatic chkIdleOutputs(input string tag);
    chk({tag, "_memen"}, 32'(MemEn), 32'd0);
    chk({tag, "_cpudone"}, 32'(CpuDone), 32'd0);
    chk({tag, "_extdone"}, 32'(ExtDone), 32'd0);
  endtask

  task automatic doReset();
    @(negedge CLK);
    CtrlRst = 1'b1;
    cpuQ.delete(); extQ.delete();
    driveReqs();
    #2;
    chkIdleOutputs("rst");
    chk("rst_extgrant", 32'(ExtGrant), 32'd0);
    chk("rst_cpurdata", 32'(CpuRData), 32'd0);
    chk("rst_extrdata", 32'(ExtRData), 32'd0);
    @(negedge CLK);
    CtrlRst = 1'b0;
    modelReset();
  endtask

  // One arbitration round, entered during an IDLE cycle (away from the edge)
  // and left during the following IDLE cycle.
  task automatic step();
    bit   cp, ep;
    int   win;
    txn_t t;
    driveReqs();
    cp = (cpuQ.size() > 0);
    ep = (extQ.size() > 0);
    if (starveM == SL && ep)                 win = 2;
    else if (prevExtM && ep && burstM < MB)  win = 2;
    else if (cp)                             win = 1;
    else if (ep)                             win = 2;
    else                                     win = 0;
    if (win == 2) begin
      burstM   = prevExtM ? ((burstM < MB) ? burstM + 1 : MB) : 1;
      starveM  = 0;
      prevExtM = 1'b1;
    end else if (win == 1) begin
      burstM   = 0;
      if (ep && starveM < SL) starveM++;
      prevExtM = 1'b0;
    end else if (!ep) begin
      burstM = 0;
    end
    @(posedge CLK); #1;
    if (win == 0) begin
      chkIdleOutputs("idle");
      return;
    end
    seqBits = {seqBits[30:0], (win == 2)};
    seqLen++;
    t = (win == 1) ? cpuQ[0] : extQ[0];
    // ISSUE
    chk("issue_memen", 32'(MemEn), 32'd1);
    chk("issue_memwe", 32'(MemWe), 32'(t.we));
    chk("issue_addr", 32'(MemAddr), 32'(t.addr));
    chk("issue_wdata", 32'(MemWData), 32'(t.data));
    chk("issue_extgrant", 32'(ExtGrant), 32'(win == 2));
    chk("issue_stall", 32'(CpuStall), 32'(cp));
    @(posedge CLK); #1;
    // WAIT
    chkIdleOutputs("wait");
    chk("wait_extgrant", 32'(ExtGrant), 32'(win == 2));
    chk("wait_stall", 32'(CpuStall), 32'(cp));
    @(posedge CLK); #1;
    // RESP
    if (t.we) refMem[t.addr[7:0]] = t.data;
    else if (win == 1) expCpuR = refMem[t.addr[7:0]];
    else expExtR = refMem[t.addr[7:0]];
    chk("resp_cpudone", 32'(CpuDone), 32'(win == 1));
    chk("resp_extdone", 32'(ExtDone), 32'(win == 2));
    chk("resp_extgrant", 32'(ExtGrant), 32'(win == 2));
    chk("resp_stall", 32'(CpuStall), 32'(cp && win != 1));
    chk("resp_cpurdata", 32'(CpuRData), 32'(expCpuR));
    chk("resp_extrdata", 32'(ExtRData), 32'(expExtR));
    if (win == 1) begin statCpuM++; void'(cpuQ.pop_front()); end
    else begin statExtM++; void'(extQ.pop_front()); end
    @(posedge CLK); #1;
  endtask

  task automatic runAll(input int maxSteps);
    int n;
    n = 0;
    while ((cpuQ.size() > 0 || extQ.size() > 0) && n < maxSteps) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(cpuQ.size() + extQ.size()), 32'd0);
  endtask

  task automatic chkStats(input string tag);
`ifdef ARB_STATS_EN
    chk({tag, "_statcpu"}, 32'(StatCpu), 32'(statCpuM[15:0]));
    chk({tag, "_statext"}, 32'(StatExt), 32'(statExtM[15:0]));
`endif
  endtask

  initial begin
    CtrlRst = 1'b1; memClr = 1'b1; pokeEn = 1'b0; pokeAddr = 8'h00; pokeData = 16'h0000;
    modelReset();
    driveReqs();
    for (int i = 0; i < 256; i++) refMem[i] = 16'h0000;
    #2;
    chkIdleOutputs("por");
    chk("por_extgrant", 32'(ExtGrant), 32'd0);
    chk("por_stall", 32'(CpuStall), 32'd0);
    chkStats("por");
    @(posedge CLK); #1;
    memClr = 1'b0;
    @(negedge CLK);
    CtrlRst = 1'b0;

    // 1: CPU read of a preloaded word
    pokeAddr = 8'h10; pokeData = 16'hBEEF; pokeEn = 1'b1;
    refMem[8'h10] = 16'hBEEF;
    @(posedge CLK); #1;
    pokeEn = 1'b0;
    cpuQ.push_back(mk(1'b0, 16'h0010, 16'h0000));
    step();
    chk("t1_cpurdata", 32'(CpuRData), 32'h0000BEEF);

    // 2: CPU write, then external read of the same word
    cpuQ.push_back(mk(1'b1, 16'h0020, 16'h1234));
    step();
    extQ.push_back(mk(1'b0, 16'h0020, 16'h0000));
    step();
    chk("t2_extrdata", 32'(ExtRData), 32'h00001234);
    chk("t2_cpurdata", 32'(CpuRData), 32'h0000BEEF);

    // 3: simultaneous requests, CPU first
    doReset();
    cpuQ.push_back(mk(1'b0, 16'h0040, 16'h0000));
    extQ.push_back(mk(1'b0, 16'h0041, 16'h0000));
    runAll(10);
    chk("t3_order", seqBits, 32'h00000001);

    // 4: continuous CPU, one external access forced in after 4 CPU grants
    doReset();
    for (int i = 0; i < 6; i++) cpuQ.push_back(mk(1'b1, 16'(16'h0050 + i), 16'(16'hA000 + i)));
    extQ.push_back(mk(1'b0, 16'h0052, 16'h0000));
    runAll(20);
    chk("t4_len", 32'(seqLen), 32'd7);
    chk("t4_order", seqBits, 32'h00000004);

    // 5: external burst of 6 writes, CPU joins after the first
    doReset();
    for (int i = 0; i < 6; i++) extQ.push_back(mk(1'b1, 16'(16'h0060 + i), 16'(16'hC000 + i)));
    step();
    cpuQ.push_back(mk(1'b0, 16'h0062, 16'h0000));
    runAll(20);
    chk("t5_len", 32'(seqLen), 32'd7);
    chk("t5_order", seqBits, 32'h0000007B);

    // 6: reset during ISSUE of an external write
    doReset();
    extQ.push_back(mk(1'b1, 16'h0030, 16'h5A5A));
    driveReqs();
    @(posedge CLK); #1;
    chk("t6_issue_memen", 32'(MemEn), 32'd1);
    chk("t6_issue_grant", 32'(ExtGrant), 32'd1);
    #2;
    CtrlRst = 1'b1;
    #1;
    chk("t6_async_memen", 32'(MemEn), 32'd0);
    chk("t6_async_memwe", 32'(MemWe), 32'd0);
    chk("t6_async_grant", 32'(ExtGrant), 32'd0);
    chk("t6_async_extdone", 32'(ExtDone), 32'd0);
    @(negedge CLK);
    CtrlRst = 1'b0;
    modelReset();
    driveReqs();
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      chkIdleOutputs("t6_after");
    end
    chkStats("t6");
    extQ.push_back(mk(1'b0, 16'h0030, 16'h0000));
    step();
    chk("t6_next_rdata", 32'(ExtRData), 32'h00000000);
    chkStats("t6_next");

    // Random traffic from both sides
    doReset();
    for (int it = 0; it < 200; it++) begin
      if (cpuQ.size() == 0 && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 6))
          cpuQ.push_back(mk(1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)), 16'($urandom)));
      end
      if (extQ.size() == 0 && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 7))
          extQ.push_back(mk(1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)), 16'($urandom)));
      end
      step();
    end
    runAll(200);
    chkStats("rand");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
